// File: rtl/divisor_segmentado_param_if.sv
// Operand-issue / result-writeback handshake bundle for the pipelined divider.
// master = operand producer and result consumer, slave = divider.
interface divisor_segmentado_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;
  logic             overflow;

  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero, overflow
  );

  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, quot, rem, div_zero, overflow
  );
endinterface

// File: rtl/divisor_segmentado_param.sv
// Pipelined restoring divider, WIDTH/BITS_PER_STAGE+2 cycles latency, one result per cycle.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready mirrors that enable.
module divisor_segmentado_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int SIGNED         = 1
) (
  input logic                      CLK,
  input logic                      RSTa,
  divisor_segmentado_param_if.slave bus
);
  localparam int W = WIDTH;
  localparam int N = WIDTH / BITS_PER_STAGE;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  // q starts as |num| and is shifted out into accu while quotient bits shift in
  typedef struct packed {
    logic         vld;
    logic [W-1:0] n_raw;
    logic [W-1:0] m;
    logic [W:0]   accu;
    logic [W-1:0] q;
    logic         sq;
    logic         sr;
    logic         dz;
    logic         ovf;
  } stage_t;

  stage_t         pipe [0:N];
  stage_t         nxt  [1:N];
  stage_t         prep_d;
  logic           en;
  logic           out_valid_r;
  logic           div_zero_r;
  logic           overflow_r;
  logic [W-1:0]   quot_r;
  logic [W-1:0]   rem_r;
  logic [W-1:0]   quot_d;
  logic [W-1:0]   rem_d;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return ((SIGNED != 0) && x[W-1]) ? -x : x;
  endfunction

  function automatic stage_t step(input stage_t s);
    stage_t r;
    r = s;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      {r.accu, r.q} = {r.accu[W-1:0], r.q, 1'b0};
      if (r.accu >= {1'b0, r.m}) begin
        r.accu = r.accu - {1'b0, r.m};
        r.q[0] = 1'b1;
      end
    end
    return r;
  endfunction

  assign en            = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_r;
  assign bus.quot      = quot_r;
  assign bus.rem       = rem_r;
  assign bus.div_zero  = div_zero_r;
  assign bus.overflow  = overflow_r;

  always_comb begin
    prep_d       = '0;
    prep_d.vld   = bus.in_valid;
    prep_d.n_raw = bus.num;
    prep_d.q     = mag(bus.num);
    prep_d.m     = mag(bus.den);
    prep_d.sq    = (SIGNED != 0) && (bus.num[W-1] ^ bus.den[W-1]);
    prep_d.sr    = (SIGNED != 0) && bus.num[W-1];
    prep_d.dz    = (bus.den == '0);
    prep_d.ovf   = (SIGNED != 0) && (bus.num == MIN_V) && (bus.den == '1);
  end

  always_comb begin
    for (int k = 1; k <= N; k++) nxt[k] = step(pipe[k-1]);
  end

  // divide-by-zero wins over overflow and over sign correction
  always_comb begin
    quot_d = pipe[N].sq ? -pipe[N].q : pipe[N].q;
    rem_d  = pipe[N].sr ? -pipe[N].accu[W-1:0] : pipe[N].accu[W-1:0];
    if (pipe[N].ovf) begin
      quot_d = MIN_V;
      rem_d  = '0;
    end
    if (pipe[N].dz) begin
      quot_d = '1;
      rem_d  = pipe[N].n_raw;
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int k = 0; k <= N; k++) pipe[k] <= '0;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      div_zero_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (en) begin
      pipe[0] <= prep_d;
      for (int k = 1; k <= N; k++) pipe[k] <= nxt[k];
      out_valid_r <= pipe[N].vld;
      quot_r      <= quot_d;
      rem_r       <= rem_d;
      div_zero_r  <= pipe[N].dz;
      overflow_r  <= pipe[N].ovf;
    end
  end
endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Bench for divisor_segmentado_param: 32-bit signed and unsigned instances in lockstep
// plus six 8-bit instances (BPS 1/2/4, unsigned/signed) for the exhaustive sweep.
module tb_divisor_segmentado_param;
  logic CLK = 1'b0;
  logic RSTa;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic        in_valid;
  logic        out_ready;
  logic [31:0] num;
  logic [31:0] den;

  divisor_segmentado_param_if #(.WIDTH(32)) bs ();
  divisor_segmentado_param_if #(.WIDTH(32)) bu ();

  assign bs.in_valid  = in_valid;
  assign bs.num       = num;
  assign bs.den       = den;
  assign bs.out_ready = out_ready;
  assign bu.in_valid  = in_valid;
  assign bu.num       = num;
  assign bu.den       = den;
  assign bu.out_ready = out_ready;

  divisor_segmentado_param #(.WIDTH(32), .BITS_PER_STAGE(1), .SIGNED(1)) dut_s (
    .CLK(CLK), .RSTa(RSTa), .bus(bs));
  divisor_segmentado_param #(.WIDTH(32), .BITS_PER_STAGE(1), .SIGNED(0)) dut_u (
    .CLK(CLK), .RSTa(RSTa), .bus(bu));

  logic       v8;
  logic [7:0] n8;
  logic [7:0] d8;
  logic       ov8 [6];
  logic       ir8 [6];
  logic       dz8 [6];
  logic       of8 [6];
  logic [7:0] q8  [6];
  logic [7:0] r8  [6];

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g8
      localparam int BPS = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
      localparam int SG  = g / 3;
      divisor_segmentado_param_if #(.WIDTH(8)) b8 ();
      assign b8.in_valid  = v8;
      assign b8.num       = n8;
      assign b8.den       = d8;
      assign b8.out_ready = 1'b1;
      assign ov8[g] = b8.out_valid;
      assign ir8[g] = b8.in_ready;
      assign dz8[g] = b8.div_zero;
      assign of8[g] = b8.overflow;
      assign q8[g]  = b8.quot;
      assign r8[g]  = b8.rem;
      divisor_segmentado_param #(.WIDTH(8), .BITS_PER_STAGE(BPS), .SIGNED(SG)) dut8 (
        .CLK(CLK), .RSTa(RSTa), .bus(b8));
    end
  endgenerate

  // Reference: plain integer division with the block's zero/overflow rules
  function automatic void ref_div(input int w, input bit sg,
                                  input longint unsigned n, input longint unsigned d,
                                  output longint unsigned q, output longint unsigned r,
                                  output bit dz, output bit ov);
    longint unsigned mask;
    longint sn, sd, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    ov = 1'b0;
    sn = (sg && n[w-1]) ? (longint'(n) - (longint'(1) << w)) : longint'(n);
    sd = (sg && d[w-1]) ? (longint'(d) - (longint'(1) << w)) : longint'(d);
    if (d == 0) begin
      dz = 1'b1;
      q  = mask;
      r  = n;
    end else if (sg && sn == -(longint'(1) << (w - 1)) && sd == -1) begin
      ov = 1'b1;
      q  = 64'd1 << (w - 1);
      r  = 0;
    end else begin
      sq = sn / sd;
      sr = sn % sd;
      q  = longint'(sq) & mask;
      r  = longint'(sr) & mask;
    end
  endfunction

  function automatic logic [31:0] gen_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation on both 32-bit DUTs and waits for its result; latency counts the accept edge.
  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] qs, output logic [31:0] rs,
                        output logic [31:0] qu, output logic [31:0] ru,
                        output logic [3:0] fl, output int lat);
    in_valid  = 1'b1;
    num       = n;
    den       = d;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    while (bs.out_valid !== 1'b1 && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    qs = bs.quot;
    rs = bs.rem;
    qu = bu.quot;
    ru = bu.rem;
    fl = {bs.div_zero, bs.overflow, bu.div_zero, bu.overflow};
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RSTa = 1'b0; in_valid = 1'b0; out_ready = 1'b0; num = '0; den = '0;
    v8 = 1'b0; n8 = '0; d8 = '0;
    repeat (3) @(posedge CLK);
    #1 RSTa = 1'b1;
    @(posedge CLK); #1;
    n_tests++; if (bs.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bs.out_valid); end
    n_tests++; if (bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bs.in_ready); end
    n_tests++; if (bs.quot !== 32'h0) begin n_fail++; $display("FAIL reset_quot: got %h expected 0", bs.quot); end
    n_tests++; if (bs.rem !== 32'h0) begin n_fail++; $display("FAIL reset_rem: got %h expected 0", bs.rem); end
    n_tests++; if ({bs.div_zero, bs.overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {bs.div_zero, bs.overflow}); end
  endtask

  task automatic test_unsigned();
    logic [31:0] qs, rs, qu, ru;
    logic [3:0]  fl;
    int          lat;
    run_op(32'd100, 32'd7, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qu !== 32'd14 || ru !== 32'd2) begin n_fail++; $display("FAIL u_100_7: got %0d r %0d expected 14 r 2", qu, ru); end
    n_tests++; if (fl[1:0] !== 2'b00) begin n_fail++; $display("FAIL u_100_7_flags: got %b expected 00", fl[1:0]); end
    n_tests++; if (lat !== 34) begin n_fail++; $display("FAIL latency_w32: got %0d expected 34", lat); end
    run_op(32'hFFFF_FFFF, 32'd1, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qu !== 32'hFFFF_FFFF || ru !== 32'h0) begin n_fail++; $display("FAIL u_max_1: got %h r %h expected ffffffff r 0", qu, ru); end
  endtask

  task automatic test_signed();
    logic [31:0] tn [3] = '{-32'sd100, 32'sd100, -32'sd100};
    logic [31:0] td [3] = '{32'sd7, -32'sd7, -32'sd7};
    logic [31:0] eq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] qs, rs, qu, ru;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(tn[i], td[i], qs, rs, qu, ru, fl, lat);
      n_tests++; if (qs !== eq[i] || rs !== er[i]) begin n_fail++; $display("FAIL s_case%0d: got %h r %h expected %h r %h", i, qs, rs, eq[i], er[i]); end
      n_tests++; if (fl[3:2] !== 2'b00) begin n_fail++; $display("FAIL s_case%0d_flags: got %b expected 00", i, fl[3:2]); end
    end
  endtask

  task automatic test_corners();
    logic [31:0] qs, rs, qu, ru;
    logic [3:0]  fl;
    int          lat;
    run_op(32'd5, 32'd0, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qs !== 32'hFFFF_FFFF || rs !== 32'd5 || fl[3:2] !== 2'b10) begin n_fail++; $display("FAIL s_div0: got %h r %h fl %b expected ffffffff r 5 fl 10", qs, rs, fl[3:2]); end
    n_tests++; if (qu !== 32'hFFFF_FFFF || ru !== 32'd5 || fl[1:0] !== 2'b10) begin n_fail++; $display("FAIL u_div0: got %h r %h fl %b expected ffffffff r 5 fl 10", qu, ru, fl[1:0]); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qs !== 32'h8000_0000 || rs !== 32'h0 || fl[3:2] !== 2'b01) begin n_fail++; $display("FAIL s_ovf: got %h r %h fl %b expected 80000000 r 0 fl 01", qs, rs, fl[3:2]); end
    n_tests++; if (qu !== 32'h0 || ru !== 32'h8000_0000 || fl[1:0] !== 2'b00) begin n_fail++; $display("FAIL u_min_max: got %h r %h fl %b expected 0 r 80000000 fl 00", qu, ru, fl[1:0]); end
    run_op(32'd0, 32'd9, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qs !== 32'h0 || rs !== 32'h0 || qu !== 32'h0 || ru !== 32'h0 || fl !== 4'b0) begin n_fail++; $display("FAIL zero_num: got %h r %h / %h r %h fl %b expected all 0", qs, rs, qu, ru, fl); end
  endtask

  typedef struct {
    logic [31:0] qs, rs, qu, ru;
    logic [3:0]  fl;
  } exp_t;

  task automatic test_back_to_back();
    exp_t            expq [$];
    exp_t            e;
    longint unsigned q, r;
    bit              dz, ov;
    int              acc = 0, ret = 0, cyc = 0;
    logic            stall_prev = 1'b0;
    logic            took;
    logic [31:0]     hq = '0, hr = '0;
    in_valid = 1'b1;
    num = gen_op();
    den = gen_op();
    while (ret < 200 && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      n_tests++; if (bs.in_ready !== (!bs.out_valid || out_ready)) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, bs.in_ready, !bs.out_valid || out_ready); end
      if (stall_prev) begin
        n_tests++; if (bs.out_valid !== 1'b1 || bs.quot !== hq || bs.rem !== hr) begin n_fail++; $display("FAIL b2b_stall_hold cyc %0d: got v%b %h r %h expected v1 %h r %h", cyc, bs.out_valid, bs.quot, bs.rem, hq, hr); end
      end
      took = in_valid && bs.in_ready;
      if (took) begin
        ref_div(32, 1'b1, num, den, q, r, dz, ov);
        e.qs = q[31:0]; e.rs = r[31:0]; e.fl[3:2] = {dz, ov};
        ref_div(32, 1'b0, num, den, q, r, dz, ov);
        e.qu = q[31:0]; e.ru = r[31:0]; e.fl[1:0] = {dz, ov};
        expq.push_back(e);
        acc++;
      end
      if (bs.out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL b2b_extra_result cyc %0d: got %h expected none", cyc, bs.quot);
        end else begin
          e = expq.pop_front();
          n_tests++;
          if (bs.quot !== e.qs || bs.rem !== e.rs || bu.quot !== e.qu || bu.rem !== e.ru ||
              {bs.div_zero, bs.overflow, bu.div_zero, bu.overflow} !== e.fl) begin
            n_fail++;
            $display("FAIL b2b_result %0d: got %h r %h / %h r %h fl %b expected %h r %h / %h r %h fl %b", ret,
                     bs.quot, bs.rem, bu.quot, bu.rem, {bs.div_zero, bs.overflow, bu.div_zero, bu.overflow},
                     e.qs, e.rs, e.qu, e.ru, e.fl);
          end
        end
        ret++;
      end
      stall_prev = bs.out_valid && !out_ready;
      hq = bs.quot;
      hr = bs.rem;
      @(posedge CLK); #1;
      cyc++;
      if (took || !in_valid) begin
        in_valid = (acc < 200) && ($urandom_range(0, 9) != 0);
        num = gen_op();
        den = gen_op();
      end
    end
    n_tests++; if (ret != 200 || acc != 200) begin n_fail++; $display("FAIL b2b_count: got %0d retired %0d accepted expected 200", ret, acc); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] qs, rs, qu, ru;
    logic [3:0]  fl;
    int          lat, w = 0, stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      num = $urandom | 32'h0100_0000;
      den = $urandom_range(1, 1000);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    while (bs.out_valid !== 1'b1 && w < 100) begin @(posedge CLK); #1; w++; end
    out_ready = 1'b0;
    n_tests++; if (bs.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup: got out_valid %b expected 1", bs.out_valid); end
    RSTa = 1'b0;
    #1;
    n_tests++; if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_handshake: got v%b rdy%b expected v0 rdy1", bs.out_valid, bs.in_ready); end
    n_tests++; if (bs.quot !== 32'h0 || bs.rem !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h r %h expected 0 r 0", bs.quot, bs.rem); end
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RSTa = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (bs.out_valid === 1'b1) stale++;
    end
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL rst_mid_stale: got %0d stale cycles expected 0", stale); end
    run_op(32'd100, 32'd7, qs, rs, qu, ru, fl, lat);
    n_tests++; if (qs !== 32'd14 || rs !== 32'd2 || lat !== 34) begin n_fail++; $display("FAIL rst_mid_fresh: got %0d r %0d lat %0d expected 14 r 2 lat 34", qs, rs, lat); end
  endtask

  // Streams all 65536 8-bit operand pairs through the six small DUTs at once
  task automatic test_param_sweep();
    longint unsigned q, r;
    bit              dz, ov;
    int              lat, bps, idx;
    bit              sg, ev;
    v8 = 1'b1;
    n8 = 8'h00;
    d8 = 8'h00;
    for (int c = 1; c <= 65536 + 12; c++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < 6; k++) begin
        bps = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 2 : 4);
        sg  = (k >= 3);
        lat = 8 / bps + 2;
        idx = c - lat;
        ev  = (idx >= 0) && (idx < 65536);
        n_tests++; if (ov8[k] !== ev) begin n_fail++; $display("FAIL sweep_valid bps%0d s%0d cyc %0d: got %b expected %b", bps, sg, c, ov8[k], ev); end
        if (ev) begin
          ref_div(8, sg, longint'(idx[15:8]), longint'(idx[7:0]), q, r, dz, ov);
          n_tests++;
          if (q8[k] !== q[7:0] || r8[k] !== r[7:0] || dz8[k] !== dz || of8[k] !== ov) begin
            n_fail++;
            $display("FAIL sweep_result bps%0d s%0d %h/%h: got %h r %h fl %b%b expected %h r %h fl %b%b",
                     bps, sg, idx[15:8], idx[7:0], q8[k], r8[k], dz8[k], of8[k], q[7:0], r[7:0], dz, ov);
          end
        end
        if (c == 1) begin
          n_tests++; if (ir8[k] !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready bps%0d s%0d: got %b expected 1", bps, sg, ir8[k]); end
        end
      end
      if (c < 65536) begin
        n8 = c[15:8];
        d8 = c[7:0];
      end else begin
        v8 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_back_to_back();
    test_reset_midstream();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
